mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised multiply/divide unit serving one FU issue slot.
- Owns the architectural HI/LO registers.
- Executes multiplies in a fixed-latency pipeline and divides in an iterative radix-2^k divider.
- Uses a start/recv handshake: the FU holds start until recv, then releases its stall.
- Successor to the fixed 32-bit single-cycle-latency MDU.
- Adds configurable width, multiply latency and divide throughput, MADD/MSUB accumulation, and flush abort.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >=8).
- MUL_STAGES, 2, multiply latency in cycles (1..4), start-accept to recv.
- DIV_BITS, 1, quotient bits retired per cycle (1 or 2); WIDTH divisible by DIV_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- mdu_op  in  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, 8 MUL, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13-15 reserved.
- mdu_start  in  1  request valid; held with stable op/operands until recv.
- mdu_srcA  in  WIDTH  rs operand.
- mdu_srcB  in  WIDTH  rt operand.
- flush  in  1  abort any in-flight operation.
- mdu_recv  out  1  one-cycle pulse: operation complete, result valid.
- mdu_result  out  WIDTH  MFHI→HI, MFLO→LO, MUL→low product, else 0.
- busy  out  1  multi-cycle operation in flight.

Behaviour:
- Reset: HI=0, LO=0, state IDLE, counters 0; busy=0, mdu_recv=0, mdu_result=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start with op 4-7:
  - Combinational recv=1 in the same cycle.
  - MFHI/MFLO drive result from current HI/LO.
  - MTHI/MTLO write srcA at the clock edge.
  - Stay IDLE.
- IDLE, start with op 0,1,8-12: latch operands and op, go to MUL, busy=1, count=MUL_STAGES-1.
- IDLE, start with op 2,3: latch operands, go to DIV, busy=1, count=WIDTH/DIV_BITS.
- Reserved op: recv=1 in the same cycle, no state change, result 0.
- MUL state:
  - When count reaches 0, go to DONE.
  - If MUL_STAGES=1, go straight from IDLE to DONE.
- MUL arithmetic (2*WIDTH bits):
  - MULT/MADD/MSUB use signed operands; MULTU/MADDU/MSUBU use unsigned.
  - MULT/MULTU: {HI,LO}=product.
  - MADD/MADDU: {HI,LO}+=product.
  - MSUB/MSUBU: {HI,LO}-=product.
  - All results wrap modulo 2^(2*WIDTH).
  - MUL: result=product[WIDTH-1:0]; HI/LO unchanged.
- DIV state:
  - Restoring divider, DIV_BITS quotient bits per cycle, on magnitudes.
  - DIV applies sign correction on the final cycle: quotient sign = sA^sB, remainder sign = sA.
  - Latency from accept to recv: WIDTH/DIV_BITS+1 cycles.
- Divide by zero:
  - No exception.
  - LO=all-ones, HI=srcA.
  - Same latency as a normal divide.
- Most-negative / -1 (DIV): LO=most-negative value, HI=0.
- DONE state:
  - recv=1 for exactly this cycle.
  - HI/LO commit at the end of this cycle.
  - Result is valid this cycle.
  - Return to IDLE.
  - A new start is not accepted in DONE; the FU re-asserts start the following cycle.
- Start while busy: ignored; operands must remain stable (FU contract).
- flush:
  - In MUL/DIV: return to IDLE next cycle, no recv, HI/LO unchanged.
  - In DONE: the commit still happens.
  - In IDLE: an mfhi/mthi-class start in the same cycle is suppressed (no write, recv=0).
- reset mid-operation: same as flush, plus HI/LO cleared.
- mdu_result holds its last valid value when recv=0; bench checks it only on recv.

Test Plan:
- Reset, then MFHI and MFLO each with start=1 → recv same cycle, result 0.
- MTLO 0x1234_5678, MTHI 0xFFFF_0000, then MULTU 0xFFFF_FFFF×2 (MUL_STAGES=2):
  - recv exactly 2 cycles after accept.
  - Subsequent MFHI→0x1, MFLO→0xFFFF_FFFE.
- HI=0, LO=5; MADD (-3)×4:
  - {HI,LO}=0xFFFF_FFFF_FFFF_FFF9.
  - MSUBU 1×1 after that → LO=0xFFFF_FFF8.
- DIV -7/2 with DIV_BITS=1: recv at cycle 33 after accept, LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
- DIV_BITS=2 regression on the same vector → recv at cycle 17.
- DIVU 10/0 → LO=0xFFFF_FFFF, HI=10.
- DIV 0x8000_0000/-1 → LO=0x8000_0000, HI=0.
- Start DIV, assert flush at cycle 5:
  - No recv ever.
  - busy drops next cycle.
  - HI/LO keep their prior values.
  - The next MUL 3×5 returns result 15 with HI/LO untouched.

Source files
------------

// File: rtl/mdu_iter.sv
// Multiply/divide unit for one FU issue slot. Owns HI/LO. Multiplies use a fixed-latency path.
// Divides use an iterative restoring divider that retires DIV_BITS quotient bits per cycle.
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mdu_op,
  input  logic             mdu_start,
  input  logic [WIDTH-1:0] mdu_srcA,
  input  logic [WIDTH-1:0] mdu_srcB,
  input  logic             flush,
  output logic             mdu_recv,
  output logic [WIDTH-1:0] mdu_result,
  output logic             busy
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / DIV_BITS + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,  OP_MULTU = 4'd1,  OP_DIV   = 4'd2,  OP_DIVU  = 4'd3,
    OP_MFHI  = 4'd4,  OP_MFLO  = 4'd5,  OP_MTHI  = 4'd6,  OP_MTLO  = 4'd7,
    OP_MUL   = 4'd8,  OP_MADD  = 4'd9,  OP_MADDU = 4'd10, OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             qneg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] res_q, res_now;
  logic             accept_mul, accept_div;

  // Multiply datapath
  logic             mul_signed;
  logic [W2-1:0]    ext_a, ext_b, product, acc;

  assign mul_signed = op_q inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL};
  assign ext_a   = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b   = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = ext_a * ext_b;
  assign acc     = {hi_q, lo_q};

  // Divide datapath: operands are reduced to magnitudes at accept.
  logic             div_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, rem_n, quo_n, q_fix, r_fix;
  logic [WIDTH:0]   trial;

  assign div_signed = (mdu_op == OP_DIV);
  assign neg_a      = div_signed && mdu_srcA[WIDTH-1];
  assign neg_b      = div_signed && mdu_srcB[WIDTH-1];
  assign mag_a      = neg_a ? -mdu_srcA : mdu_srcA;
  assign mag_b      = neg_b ? -mdu_srcB : mdu_srcB;
  assign q_fix      = qneg_q ? -quo_q : quo_q;
  assign r_fix      = rneg_q ? -rem_q : rem_q;

  // DIV_BITS restoring steps chained within one cycle; quo shifts dividend out and quotient in.
  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    trial = '0;
    for (int unsigned i = 0; i < DIV_BITS; i++) begin
      trial = {rem_n, quo_n[WIDTH-1]};
      quo_n = {quo_n[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial    = trial - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mdu_recv   = 1'b0;
    res_now    = '0;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mdu_start && !flush) begin
          case (mdu_op)
            OP_MFHI: begin mdu_recv = 1'b1; res_now = hi_q; end
            OP_MFLO: begin mdu_recv = 1'b1; res_now = lo_q; end
            OP_MTHI: begin mdu_recv = 1'b1; hi_d = mdu_srcA; end
            OP_MTLO: begin mdu_recv = 1'b1; lo_d = mdu_srcA; end
            OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              accept_mul = 1'b1;
              state_d    = (MUL_STAGES == 1) ? DONE : MUL;
              count_d    = CW'(MUL_STAGES - 1);
            end
            OP_DIV, OP_DIVU: begin
              accept_div = 1'b1;
              state_d    = DIV;
              count_d    = CW'(WIDTH / DIV_BITS);
            end
            default: mdu_recv = 1'b1;
          endcase
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - 1'b1;
          if (count_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        mdu_recv = 1'b1;
        state_d  = IDLE;
        case (op_q)
          OP_DIV, OP_DIVU: begin
            lo_d = dz_q ? '1  : q_fix;
            hi_d = dz_q ? a_q : r_fix;
          end
          OP_MULT, OP_MULTU: {hi_d, lo_d} = product;
          OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + product;
          OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - product;
          OP_MUL:            res_now = product[WIDTH-1:0];
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (reset) mdu_recv = 1'b0;
  end

  assign busy       = (state_q != IDLE);
  assign mdu_result = mdu_recv ? res_now : res_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (mdu_recv) res_q <= res_now;
      if (accept_mul) begin
        op_q <= op_e'(mdu_op);
        a_q  <= mdu_srcA;
        b_q  <= mdu_srcB;
      end
      if (accept_div) begin
        op_q   <= op_e'(mdu_op);
        a_q    <= mdu_srcA;
        quo_q  <= mag_a;
        dvs_q  <= mag_b;
        rem_q  <= '0;
        qneg_q <= neg_a ^ neg_b;
        rneg_q <= neg_a;
        dz_q   <= (mdu_srcB == '0);
      end
      if (state_q == DIV && !flush) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
      end
    end
  end

endmodule
